// File: rtl/mul_stage_arbiter.sv
// Round-robin front end that shares one mod_MulStage among NREQ requesters and
// steers each in-order result back to its issuer through a tag FIFO.
module mul_stage_arbiter #(
    parameter int NREQ  = 4,
    parameter int TAGW  = 2,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [16*NREQ-1:0]        req_a,
    input  logic [16*NREQ-1:0]        req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [15:0]               rsp_data,
    output logic                      mul_srcReady,
    input  logic                      mul_readyForInput,
    output logic [15:0]               mul_in_A,
    output logic [15:0]               mul_in_B,
    input  logic                      mul_outputReadyEn,
    output logic                      mul_destReady,
    input  logic [15:0]               mul_result,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic                      err_orphan
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [TAGW-1:0] rrPtr;
    logic [TAGW-1:0] grantIdx;
    logic            grantValid;
    logic [TAGW:0]   scanIdx;

    logic [TAGW-1:0] tagMem [DEPTH];
    logic [PTRW-1:0] wrPtr;
    logic [PTRW-1:0] rdPtr;
    logic [CNTW-1:0] count;
    logic [TAGW-1:0] headTag;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            errOrphan;

    // Rotating priority scan starting at rrPtr, wrapping modulo NREQ.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        scanIdx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scanIdx = {1'b0, rrPtr} + (TAGW+1)'(k);
            if (scanIdx >= (TAGW+1)'(NREQ))
                scanIdx = scanIdx - (TAGW+1)'(NREQ);
            if (!grantValid && req_valid[scanIdx[TAGW-1:0]]) begin
                grantValid = 1'b1;
                grantIdx   = scanIdx[TAGW-1:0];
            end
        end
    end

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign headTag = tagMem[rdPtr];

    // Gating with rst keeps requesters from seeing an acceptance while held in reset.
    assign mul_srcReady = grantValid & rst & ~full;
    assign req_ready    = (mul_srcReady && mul_readyForInput) ? (NREQ'(1) << grantIdx) : '0;
    assign mul_in_A     = (grantValid && rst) ? req_a[{grantIdx, 4'b0000} +: 16] : 16'h0000;
    assign mul_in_B     = (grantValid && rst) ? req_b[{grantIdx, 4'b0000} +: 16] : 16'h0000;

    assign rsp_valid     = (mul_outputReadyEn && !empty) ? (NREQ'(1) << headTag) : '0;
    assign mul_destReady = ~empty & rsp_ready[headTag];
    assign rsp_data      = mul_result;

    assign push = mul_srcReady & mul_readyForInput;
    assign pop  = mul_outputReadyEn & mul_destReady;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rrPtr     <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            errOrphan <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                tagMem[i] <= '0;
        end else begin
            if (push) begin
                tagMem[wrPtr] <= grantIdx;
                wrPtr         <= wrPtr + 1'b1;
                rrPtr         <= (grantIdx == TAGW'(NREQ-1)) ? '0 : grantIdx + 1'b1;
            end
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (mul_outputReadyEn && empty)
                errOrphan <= 1'b1;
        end
    end

    assign outstanding = count;
    assign err_orphan  = errOrphan;

endmodule

// File: tb/tb_mul_stage_arbiter.sv
// Directed bench for mul_stage_arbiter; the bench plays both the requesters and
// the multiplier stage handshake.
module tb_mul_stage_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  reqValid;
    logic [63:0] reqA;
    logic [63:0] reqB;
    logic [3:0]  reqReady;
    logic [3:0]  rspValid;
    logic [3:0]  rspReady;
    logic [15:0] rspData;
    logic        mulSrcReady;
    logic        mulReadyForInput;
    logic [15:0] mulInA;
    logic [15:0] mulInB;
    logic        mulOutputReadyEn;
    logic        mulDestReady;
    logic [15:0] mulResult;
    logic [2:0]  outstanding;
    logic        errOrphan;

    int testsRun;
    int testsFailed;

    mul_stage_arbiter #(.NREQ(4), .TAGW(2), .DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (reqValid),
        .req_a             (reqA),
        .req_b             (reqB),
        .req_ready         (reqReady),
        .rsp_valid         (rspValid),
        .rsp_ready         (rspReady),
        .rsp_data          (rspData),
        .mul_srcReady      (mulSrcReady),
        .mul_readyForInput (mulReadyForInput),
        .mul_in_A          (mulInA),
        .mul_in_B          (mulInB),
        .mul_outputReadyEn (mulOutputReadyEn),
        .mul_destReady     (mulDestReady),
        .mul_result        (mulResult),
        .outstanding       (outstanding),
        .err_orphan        (errOrphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] ready, input logic outEn);
        reqValid         = valid;
        rspReady         = ready;
        mulOutputReadyEn = outEn;
        settle();
    endtask

    task automatic doReset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        testsRun         = 0;
        testsFailed      = 0;
        rst              = 1'b0;
        reqValid         = '0;
        reqA             = '0;
        reqB             = '0;
        rspReady         = '0;
        mulReadyForInput = 1'b1;
        mulOutputReadyEn = 1'b0;
        mulResult        = 16'hABCD;
        #1;

        // Reset values
        checkOutput("rst_outstanding", 32'(outstanding), 0);
        checkOutput("rst_orphan", 32'(errOrphan), 0);
        checkOutput("rst_reqReady", 32'(reqReady), 0);
        checkOutput("rst_rspValid", 32'(rspValid), 0);
        checkOutput("rst_srcReady", 32'(mulSrcReady), 0);
        checkOutput("rst_destReady", 32'(mulDestReady), 0);
        checkOutput("rst_inA", 32'(mulInA), 0);
        checkOutput("rst_rspData", 32'(rspData), 32'hABCD);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Single issue and return
        reqA[15:0] = 16'h57B7;
        reqB[15:0] = 16'hD7B7;
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        checkOutput("single_reqReady", 32'(reqReady), 32'b0001);
        checkOutput("single_srcReady", 32'(mulSrcReady), 1);
        checkOutput("single_inA", 32'(mulInA), 32'h57B7);
        checkOutput("single_inB", 32'(mulInB), 32'hD7B7);
        step();
        checkOutput("single_out1", 32'(outstanding), 1);
        mulResult = 16'hF371;
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("single_rspValid", 32'(rspValid), 32'b0001);
        checkOutput("single_rspData", 32'(rspData), 32'hF371);
        checkOutput("single_destHeld", 32'(mulDestReady), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("single_hold_valid", 32'(rspValid), 32'b0001);
            checkOutput("single_hold_out", 32'(outstanding), 1);
        end
        applyStimulus(4'b0000, 4'b0001, 1'b1);
        checkOutput("single_destReady", 32'(mulDestReady), 1);
        step();
        checkOutput("single_out0", 32'(outstanding), 0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Round robin, full FIFO and back-pressure
        doReset();
        for (int i = 0; i < 4; i++) begin
            reqA[16*i +: 16] = 16'(16'h1000 + i);
            reqB[16*i +: 16] = 16'(16'h2000 + i);
        end
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rr_grant", 32'(reqReady), 32'(4'b0001 << i));
            checkOutput("rr_inA", 32'(mulInA), 32'h1000 + i);
            step();
            checkOutput("rr_outstanding", 32'(outstanding), i + 1);
        end
        checkOutput("full_srcReady", 32'(mulSrcReady), 0);
        checkOutput("full_reqReady", 32'(reqReady), 0);
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        checkOutput("full_rspValid0", 32'(rspValid), 32'b0001);
        checkOutput("full_destBlocked", 32'(mulDestReady), 0);
        applyStimulus(4'b1111, 4'b0001, 1'b1);
        checkOutput("full_destReady", 32'(mulDestReady), 1);
        step();
        checkOutput("pop_out3", 32'(outstanding), 3);
        checkOutput("reissue_grant0", 32'(reqReady), 32'b0001);
        checkOutput("head1_rspValid", 32'(rspValid), 32'b0010);
        checkOutput("head1_nonHead", 32'(mulDestReady), 0);
        step();
        checkOutput("reissue_out4", 32'(outstanding), 4);
        checkOutput("reissue_full", 32'(mulSrcReady), 0);
        applyStimulus(4'b1111, 4'b0010, 1'b1);
        checkOutput("head1_dest", 32'(mulDestReady), 1);
        step();
        checkOutput("pop1_out3", 32'(outstanding), 3);
        checkOutput("reissue_grant1", 32'(reqReady), 32'b0010);
        checkOutput("head2_rspValid", 32'(rspValid), 32'b0100);
        checkOutput("nonHead_dest", 32'(mulDestReady), 0);
        step();
        checkOutput("nonHead_out4", 32'(outstanding), 4);
        checkOutput("nonHead_dest_full", 32'(mulDestReady), 0);
        step();
        checkOutput("nonHead_noPop", 32'(outstanding), 4);
        checkOutput("nonHead_headStill2", 32'(rspValid), 32'b0100);
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] expHead;
            expHead = 2'(2 + i);
            checkOutput("drain_rspValid", 32'(rspValid), 32'(4'b0001 << expHead));
            step();
        end
        checkOutput("drain_out0", 32'(outstanding), 0);

        // Orphan result
        checkOutput("orphan_rspValid", 32'(rspValid), 0);
        checkOutput("orphan_dest", 32'(mulDestReady), 0);
        checkOutput("orphan_before", 32'(errOrphan), 0);
        step();
        checkOutput("orphan_set", 32'(errOrphan), 1);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        step();
        step();
        checkOutput("orphan_sticky", 32'(errOrphan), 1);

        // Reset mid-operation
        doReset();
        checkOutput("reset_orphanClr", 32'(errOrphan), 0);
        applyStimulus(4'b0111, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("mid_grant", 32'(reqReady), 32'(4'b0001 << i));
            step();
        end
        checkOutput("mid_out3", 32'(outstanding), 3);
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        checkOutput("mid_rrPtr3", 32'(reqReady), 32'b1000);
        #2;
        rst = 1'b0;
        mulOutputReadyEn = 1'b1;
        #1;
        checkOutput("async_out0", 32'(outstanding), 0);
        checkOutput("async_reqReady", 32'(reqReady), 0);
        checkOutput("async_srcReady", 32'(mulSrcReady), 0);
        checkOutput("async_inA", 32'(mulInA), 0);
        checkOutput("async_rspValid", 32'(rspValid), 0);
        checkOutput("async_dest", 32'(mulDestReady), 0);
        mulOutputReadyEn = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        settle();
        checkOutput("post_grant0", 32'(reqReady), 32'b0001);
        checkOutput("post_inA", 32'(mulInA), 32'h1000);
        checkOutput("post_orphan", 32'(errOrphan), 0);
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        checkOutput("post_grant3", 32'(reqReady), 32'b1000);
        checkOutput("post_inB", 32'(mulInB), 32'h2003);
        step();
        checkOutput("post_out1", 32'(outstanding), 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
